// File: rtl/sd_init_seq_pkg.sv
// sd_pkg: command indices, register map and state/error types for the SD init sequencer
package sd_pkg;
  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [3:0] REG_ARG0 = 4'd0;
  localparam logic [3:0] REG_ARG1 = 4'd1;
  localparam logic [3:0] REG_ARG2 = 4'd2;
  localparam logic [3:0] REG_ARG3 = 4'd3;
  localparam logic [3:0] REG_CMD  = 4'd4;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DELAY, S_DONE, S_FAIL
  } seq_state_t;
  typedef enum logic [2:0] {
    ERR_NONE, ERR_CMD8_TIMEOUT, ERR_CMD8_ECHO, ERR_CMD55_TIMEOUT,
    ERR_ACMD41_TIMEOUT, ERR_ACMD41_RETRIES
  } err_code_t;
endpackage

// File: rtl/sd_init_seq_reg_burst.sv
// sd_reg_burst: emits the five register writes (arg bytes LSB first, then cmd) that launch one command
//   clk, rst_n      clock, async active-low reset
//   go              pulse; captures cmd/arg, first write appears the next cycle
//   cmd, arg        command index and argument captured on go
//   addr, data, cs  register write port; addr/data hold after the burst
//   last            high during the cmd write (fifth write)
import sd_pkg::*;
module sd_reg_burst (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  output logic [3:0]  addr,
  output logic [7:0]  data,
  output logic        cs,
  output logic        last
);
  logic [31:0] rest;
  assign last = cs && addr == REG_CMD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      data <= '0;
      cs   <= 1'b0;
      rest <= '0;
    end else if (go) begin
      addr <= REG_ARG0;
      data <= arg[7:0];
      cs   <= 1'b1;
      rest <= {2'b00, cmd, arg[31:8]};
    end else if (cs) begin
      cs <= !last;
      if (!last) begin
        addr <= addr + 4'd1;
        data <= rest[7:0];
        rest <= rest >> 8;
      end
    end
  end
endmodule

// File: rtl/sd_init_seq.sv
// sd_init_seq: drives CMD0, CMD8 and the CMD55/ACMD41 loop through sd_controller's register port
//   clk, rst_n                  clock, async active-low reset
//   i_start                     pulse; starts (or restarts from DONE/FAIL) the sequence
//   o_addr, o_data, o_cs        sd_controller register write port
//   i_cmd_done, i_timeout, i_resp  command completion, no-response flag and payload
//   o_busy                      sequence in progress
//   o_done, o_error, o_err_code sticky outcome and failure reason
//   o_ccs                       OCR card capacity status, valid with o_done
module sd_init_seq
  import sd_pkg::*;
#(
  parameter int          ACMD41_RETRIES = 1000,
  parameter int          RETRY_DELAY    = 1000,
  parameter logic [31:0] CMD8_ARG       = 32'h0000_01AA,
  parameter logic [31:0] ACMD41_ARG     = 32'h4018_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic [3:0]  o_addr,
  output logic [7:0]  o_data,
  output logic        o_cs,
  input  logic        i_cmd_done,
  input  logic        i_timeout,
  input  logic [31:0] i_resp,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_err_code,
  output logic        o_ccs
);
  localparam int AW = $clog2(ACMD41_RETRIES + 1);
  localparam int DW = $clog2(RETRY_DELAY + 1);
  seq_state_t state_q, state_d;
  err_code_t err_q, err_d;
  logic [5:0] cmd_q, cmd_d;
  logic [AW-1:0] acnt_q, acnt_d, acnt_inc;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [31:0] resp_q, resp_d, arg_d;
  logic to_q, to_d, ccs_q, ccs_d, go, last, unused_resp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      cmd_q   <= CMD0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
      resp_q  <= '0;
      to_q    <= 1'b0;
      ccs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
      resp_q  <= resp_d;
      to_q    <= to_d;
      ccs_q   <= ccs_d;
    end
  end
  assign acnt_inc = acnt_q + AW'(1);
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cmd_d   = cmd_q;
    acnt_d  = acnt_q;
    dcnt_d  = dcnt_q;
    resp_d  = resp_q;
    to_d    = to_q;
    ccs_d   = ccs_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL:
        if (i_start) begin
          state_d = S_LOAD;
          cmd_d   = CMD0;
          err_d   = ERR_NONE;
          acnt_d  = '0;
          ccs_d   = 1'b0;
        end
      S_LOAD: state_d = last ? S_WAIT : S_LOAD;
      S_WAIT:
        if (i_cmd_done) begin
          state_d = S_CHECK;
          to_d    = i_timeout;
          resp_d  = i_resp;
        end
      S_CHECK:
        case (cmd_q)
          CMD0: begin
            state_d = S_LOAD;
            cmd_d   = CMD8;
          end
          CMD8: begin
            state_d = to_q || resp_q[11:0] != CMD8_ARG[11:0] ? S_FAIL : S_LOAD;
            err_d   = to_q ? ERR_CMD8_TIMEOUT : resp_q[11:0] != CMD8_ARG[11:0] ? ERR_CMD8_ECHO : ERR_NONE;
            cmd_d   = CMD55;
          end
          CMD55: begin
            state_d = to_q ? S_FAIL : S_LOAD;
            err_d   = to_q ? ERR_CMD55_TIMEOUT : ERR_NONE;
            cmd_d   = ACMD41;
          end
          default:
            if (to_q) begin
              state_d = S_FAIL;
              err_d   = ERR_ACMD41_TIMEOUT;
            end else if (resp_q[31]) begin
              state_d = S_DONE;
              ccs_d   = resp_q[30];
            end else begin
              // Card still powering up: count the attempt and pause before the next CMD55.
              acnt_d  = acnt_inc;
              dcnt_d  = '0;
              cmd_d   = CMD55;
              state_d = acnt_inc == AW'(ACMD41_RETRIES) ? S_FAIL : S_DELAY;
              err_d   = acnt_inc == AW'(ACMD41_RETRIES) ? ERR_ACMD41_RETRIES : ERR_NONE;
            end
        endcase
      S_DELAY:
        if (dcnt_q == DW'(RETRY_DELAY - 1)) state_d = S_LOAD;
        else dcnt_d = dcnt_q + DW'(1);
      default: state_d = S_IDLE;
    endcase
  end
  // The burst captures the command chosen on the same edge the FSM enters LOAD.
  assign go = state_d == S_LOAD && state_q != S_LOAD;
  assign arg_d = cmd_d == CMD8 ? CMD8_ARG : cmd_d == ACMD41 ? ACMD41_ARG : '0;
  assign unused_resp = ^resp_q[29:12];
  sd_reg_burst u_burst (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go),
    .cmd  (cmd_d),
    .arg  (arg_d),
    .addr (o_addr),
    .data (o_data),
    .cs   (o_cs),
    .last (last)
  );
  assign o_busy     = state_q == S_LOAD || state_q == S_WAIT || state_q == S_CHECK || state_q == S_DELAY;
  assign o_done     = state_q == S_DONE;
  assign o_error    = state_q == S_FAIL;
  assign o_err_code = err_q;
  assign o_ccs      = ccs_q;
endmodule
